b01_serial_fsm: RTL and testbench

- Eight-state Moore/Mealy-registered FSM that compares two serial bit streams, `line1` and `line2`, one bit per clock.
- Produces a registered serial result `outp` and a registered overflow flag `overflw`.
- Used as a small control/benchmark block (ITC'99 b01 class).
- Sits directly under a stimulus driver that changes inputs shortly after each rising clock edge.

---
 rtl/b01_serial_fsm.sv | 87 ++++++++
 tb/tb_b01_serial_fsm.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/b01_serial_fsm.sv
// Serial two-stream comparator FSM (ITC'99 b01 class); outputs registered, one cycle after the sampling edge.
// No handshake: line1/line2 are consumed on every rising edge, there is no backpressure.
module b01_serial_fsm (
    input  logic clock,
    input  logic reset,
    input  logic line1,
    input  logic line2,
    input  logic __obs,
    output logic outp,
    output logic overflw
);

    typedef enum logic [2:0] {
        ST_A   = 3'd0,
        ST_B   = 3'd1,
        ST_C   = 3'd2,
        ST_E   = 3'd3,
        ST_F   = 3'd4,
        ST_G   = 3'd5,
        ST_WF0 = 3'd6,
        ST_WF1 = 3'd7
    } state_t;

    state_t state;

    logic x_bit;
    logic and_bit;
    logic or_bit;

    // The harness strobe is deliberately kept out of every functional path.
    logic obs_unused;
    assign obs_unused = __obs;

    assign x_bit   = line1 ^ line2;
    assign and_bit = line1 & line2;
    assign or_bit  = line1 | line2;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_A;
            outp    <= 1'b0;
            overflw <= 1'b0;
        end else begin
            overflw <= 1'b0;
            case (state)
                ST_A: begin
                    state <= and_bit ? ST_F : ST_B;
                    outp  <= x_bit;
                end
                ST_E: begin
                    state   <= and_bit ? ST_F : ST_B;
                    outp    <= x_bit;
                    overflw <= 1'b1;
                end
                ST_B: begin
                    state <= and_bit ? ST_G : ST_C;
                    outp  <= x_bit;
                end
                ST_F: begin
                    state <= or_bit ? ST_G : ST_C;
                    outp  <= ~x_bit;
                end
                ST_C: begin
                    state <= and_bit ? ST_WF1 : ST_WF0;
                    outp  <= x_bit;
                end
                ST_G: begin
                    state <= or_bit ? ST_WF1 : ST_WF0;
                    outp  <= ~x_bit;
                end
                ST_WF0: begin
                    state <= and_bit ? ST_E : ST_A;
                    outp  <= x_bit;
                end
                ST_WF1: begin
                    state <= or_bit ? ST_E : ST_A;
                    outp  <= ~x_bit;
                end
                default: begin
                    state <= ST_A;
                    outp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b01_serial_fsm.sv
// Scoreboard bench for b01_serial_fsm: a table-driven reference model pushes expected results per vector.
module tb_b01_serial_fsm;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic line1 = 1'b0;
    logic line2 = 1'b0;
    logic obs   = 1'b0;
    logic outp;
    logic overflw;

    b01_serial_fsm dut (
        .clock   (clock),
        .reset   (reset),
        .line1   (line1),
        .line2   (line2),
        .__obs   (obs),
        .outp    (outp),
        .overflw (overflw)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       o;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference tables indexed by state encoding A,B,C,E,F,G,WF0,WF1.
    logic [2:0] tgt_hi [8];
    logic [2:0] tgt_lo [8];
    logic       sel_or [8];
    logic       inv_o  [8];
    logic [2:0] mstate = 3'd0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic apply(input logic rst, input logic l1, input logic l2, input string tag);
        exp_t e;
        logic cond;
        exp_t r;
        reset = rst;
        line1 = l1;
        line2 = l2;
        obs   = ~obs;
        if (rst) begin
            e.st = 3'd0;
            e.o  = 1'b0;
            e.ov = 1'b0;
        end else begin
            cond = sel_or[mstate] ? (l1 | l2) : (l1 & l2);
            e.st = cond ? tgt_hi[mstate] : tgt_lo[mstate];
            e.o  = (l1 ^ l2) ^ inv_o[mstate];
            e.ov = (mstate == 3'd3);
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        r = exp_q.pop_front();
        mstate = r.st;
        chk({tag, ".state"}, {5'd0, dut.state}, {5'd0, r.st});
        chk({tag, ".outp"},  {7'd0, outp},      {7'd0, r.o});
        chk({tag, ".ovf"},   {7'd0, overflw},   {7'd0, r.ov});
    endtask

    task automatic drive_seq(input logic [9:0] pairs, input int n, input string tag);
        for (int i = 0; i < n; i++)
            apply(1'b0, pairs[2*(n-1-i)+1], pairs[2*(n-1-i)], tag);
    endtask

    // Hard-coded expectations from the test plan, checked alongside the model.
    task automatic expect_now(input logic [2:0] st, input logic o, input logic ov, input string tag);
        chk({tag, ".plan_state"}, {5'd0, dut.state}, {5'd0, st});
        chk({tag, ".plan_outp"},  {7'd0, outp},      {7'd0, o});
        chk({tag, ".plan_ovf"},   {7'd0, overflw},   {7'd0, ov});
    endtask

    initial begin
        tgt_hi = '{3'd4, 3'd5, 3'd7, 3'd4, 3'd5, 3'd7, 3'd3, 3'd3};
        tgt_lo = '{3'd1, 3'd2, 3'd6, 3'd1, 3'd2, 3'd6, 3'd0, 3'd0};
        sel_or = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        inv_o  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        #2;
        apply(1'b1, 1'b1, 1'b0, "rst1");
        expect_now(3'd0, 1'b0, 1'b0, "rst1");
        apply(1'b1, 1'b1, 1'b1, "rst3a");
        apply(1'b1, 1'b0, 1'b1, "rst3b");
        apply(1'b1, 1'b1, 1'b0, "rst3c");
        expect_now(3'd0, 1'b0, 1'b0, "rst3");

        // Carry path: F, C, WF1, E, B
        apply(1'b0, 1'b1, 1'b1, "carry0"); expect_now(3'd4, 1'b0, 1'b0, "carry0");
        apply(1'b0, 1'b0, 1'b0, "carry1"); expect_now(3'd2, 1'b1, 1'b0, "carry1");
        apply(1'b0, 1'b1, 1'b1, "carry2"); expect_now(3'd7, 1'b0, 1'b0, "carry2");
        apply(1'b0, 1'b1, 1'b0, "carry3"); expect_now(3'd3, 1'b0, 1'b0, "carry3");
        apply(1'b0, 1'b0, 1'b0, "carry4"); expect_now(3'd1, 1'b0, 1'b1, "carry4");

        // No-carry path: B, C, WF0, E, B
        apply(1'b1, 1'b0, 1'b0, "rstn");
        drive_seq(10'b00_00_00_11_10, 5, "nocarry");
        expect_now(3'd1, 1'b1, 1'b1, "nocarry_end");

        // Inverted-output states and wrap from WF0
        apply(1'b1, 1'b0, 1'b0, "rsti");
        apply(1'b0, 1'b1, 1'b1, "inv_f");
        apply(1'b0, 1'b1, 1'b0, "inv_g");  expect_now(3'd5, 1'b0, 1'b0, "inv_g");
        apply(1'b0, 1'b0, 1'b0, "inv_w0"); expect_now(3'd6, 1'b1, 1'b0, "inv_w0");
        apply(1'b0, 1'b0, 1'b1, "wrap0");  expect_now(3'd0, 1'b1, 1'b0, "wrap0");

        // Wrap from WF1 via A -> F -> G -> WF1
        drive_seq(10'b00_00_11_10_11, 3, "to_wf1");
        expect_now(3'd7, 1'b1, 1'b0, "to_wf1");
        apply(1'b0, 1'b0, 1'b0, "wrap1");  expect_now(3'd0, 1'b1, 1'b0, "wrap1");

        // Mid-operation reset from WF1
        drive_seq(10'b00_00_11_10_11, 3, "to_wf1b");
        apply(1'b1, 1'b1, 1'b1, "midrst"); expect_now(3'd0, 1'b0, 1'b0, "midrst");

        // Random traffic with occasional resets; obs toggles every vector
        for (int i = 0; i < 300; i++)
            apply(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), "rand");

        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
